saturn_rstk_arbiter: RTL
========================

Name: saturn_rstk_arbiter

Overview:
- Owns the 8-entry, 20-bit return stack (RSTK) and its pointer.
- Arbitrates access between three requesters:
  - Port A: PC/jump sequencer (GOSUB push, RTN pop).
  - Port B: exec unit (RSTK=C push, C=RSTK pop).
  - Port D: debugger, read-only.
- Serialises all accesses through a small FSM: one access in flight, one ack per access. Sits beside the PC unit, which no longer holds RSTK storage.

Parameters:
- ADDR_W, 20, width of a stack entry.
- STARVE_LIMIT, 3, consecutive A grants while B is pending before B is forced ahead of A.

Ports:
- i_clk  in  1  core clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_clk_en  in  1  advance FSM only when high.
- i_a_req  in  1  port A request, held until o_a_ack.
- i_a_pop  in  1  port A op: 0 push, 1 pop.
- i_a_data  in  ADDR_W  port A push value.
- o_a_ack  out  1  one-cycle completion pulse.
- o_a_data  out  ADDR_W  pop result, valid while o_a_ack=1.
- i_b_req, i_b_pop, i_b_data, o_b_ack, o_b_data: same as port A, for port B.
- i_dbg_req  in  1  debugger read request.
- i_dbg_ptr  in  3  entry to read.
- o_dbg_ack  out  1  one-cycle pulse.
- o_dbg_data  out  ADDR_W  RSTK[i_dbg_ptr] as latched at grant.
- o_rstk_ptr  out  3  current top-of-stack index.
- o_rstk_count  out  4  occupied entries, 0..8.
- o_busy  out  1  high in INIT and EXEC.
- o_overflow  out  1  pulse: push while count was 8.
- o_underflow  out  1  pulse: pop while count was 0.

Behaviour:
- Reset (asynchronous, i_reset_n=0):
  - state=INIT, init index=0, ptr=7, count=0.
  - All acks, o_overflow and o_underflow = 0.
  - o_*_data = 0, o_busy = 1, starvation counter = 0.
  - Any in-flight access is discarded without ack.
- INIT:
  - On each i_clk_en cycle, clears RSTK[index] and increments index.
  - After index 7 is cleared, goes to IDLE.
  - Takes 8 enabled cycles. Requests are ignored; they stay pending.
- IDLE, i_clk_en=1, any request present:
  - Grant priority is A > B > D.
  - Exception: if starvation counter == STARVE_LIMIT and B is requesting, B wins.
  - On grant, latch winner, op, data and dbg_ptr, then go to EXEC.
  - Starvation counter:
    - increments when A is granted while B is requesting;
    - clears when B is granted or B is not requesting;
    - saturates at STARVE_LIMIT.
- EXEC, i_clk_en=1: perform the access, pulse the winner's ack for exactly one cycle, return to IDLE.
  - Latency: request seen in IDLE → ack on the 2nd enabled clock.
  - Minimum of 2 enabled cycles per access.
- Push:
  - ptr ← ptr+1 (mod 8); RSTK[ptr+1] ← data.
  - count ← min(count+1, 8).
  - If count was 8: the oldest entry is overwritten and o_overflow pulses with the ack.
- Pop, count>0:
  - o_x_data = RSTK[ptr]; RSTK[ptr] ← 0.
  - ptr ← ptr−1 (mod 8); count−1.
- Pop, count=0:
  - o_x_data = 0; ptr and count unchanged.
  - o_underflow pulses with the ack.
- Debugger read: o_dbg_data = RSTK[latched ptr]. No state change; ptr and count are unaffected.
- Requesters must drop req in the cycle after ack. A req still high in IDLE is a new transaction.
- i_clk_en=0: FSM, storage and outputs hold; ack pulses are not stretched (acks are 0 when i_clk_en=0).
- Width rule: all pointer arithmetic is 3-bit wrap. count is 4-bit and never exceeds 8.
- Simultaneous A and B requests are never merged; each completes as its own transaction.

Test Plan:
- Reset release, no requests → o_busy=1 for 8 enabled cycles, then 0; ptr=7, count=0; all 8 debugger reads return 00000.
- A push 12345, then A pop → each ack on the 2nd enabled cycle; pop returns 12345; ptr back to 7, count=0; entry cleared to 00000.
- 9 pushes of 00001..00009, then 8 pops → o_overflow only on the 9th push; pops return 00009 down to 00002; a further pop returns 00000 with o_underflow=1.
- A and B requesting continuously, STARVE_LIMIT=3 → grant order A,A,A,B,A,A,A,B; no ack lost.
- Debugger read of ptr 0 interleaved with A pushes → o_dbg_data equals RSTK[0]; count and ptr unchanged by the read.
- Deassert i_reset_n while in EXEC of a push → no ack; after INIT, count=0 and the push value is absent.

Source files
------------

// File: rtl/saturn_rstk_arbiter.sv
// Return-stack owner: 8x ADDR_W storage, pointer/count, and a 3-port (A, B, debugger) serialising arbiter.
// Latency: ack on the 2nd enabled clock after a request is seen in IDLE; at most one access in flight.
// Backpressure: requests are held until acked; nothing advances while i_clk_en is low, and acks are masked then.
module saturn_rstk_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_clk_en,
    input  logic              i_a_req,
    input  logic              i_a_pop,
    input  logic [ADDR_W-1:0] i_a_data,
    output logic              o_a_ack,
    output logic [ADDR_W-1:0] o_a_data,
    input  logic              i_b_req,
    input  logic              i_b_pop,
    input  logic [ADDR_W-1:0] i_b_data,
    output logic              o_b_ack,
    output logic [ADDR_W-1:0] o_b_data,
    input  logic              i_dbg_req,
    input  logic [2:0]        i_dbg_ptr,
    output logic              o_dbg_ack,
    output logic [ADDR_W-1:0] o_dbg_data,
    output logic [2:0]        o_rstk_ptr,
    output logic [3:0]        o_rstk_count,
    output logic              o_busy,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;

    localparam logic [1:0] W_A = 2'd0;
    localparam logic [1:0] W_B = 2'd1;
    localparam logic [1:0] W_D = 2'd2;

    logic [1:0]        state;
    logic [2:0]        init_idx;
    logic [2:0]        ptr;
    logic [3:0]        count;
    logic [SW-1:0]     starve;
    logic [1:0]        win;
    logic              op_pop;
    logic [ADDR_W-1:0] op_data;
    logic [2:0]        dbg_ptr_q;
    logic [ADDR_W-1:0] rstk [8];

    logic a_ack_q, b_ack_q, dbg_ack_q, ovf_q, unf_q;

    logic              gnt_vld;
    logic [1:0]        gnt_win;
    logic [SW-1:0]     starve_nxt;
    logic [2:0]        ptr_inc, ptr_dec;
    logic              empty, full;
    logic [ADDR_W-1:0] pop_dat;
    logic              wr_en;
    logic [2:0]        wr_idx;
    logic [ADDR_W-1:0] wr_dat;

    assign ptr_inc = ptr + 3'd1;
    assign ptr_dec = ptr - 3'd1;
    assign empty   = (count == 4'd0);
    assign full    = (count == 4'd8);
    assign pop_dat = empty ? '0 : rstk[ptr];

    // B jumps the queue once A has won STARVE_LIMIT times in a row over it.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_win = W_A;
        if (i_b_req && starve == STARVE_MAX) begin
            gnt_vld = 1'b1;
            gnt_win = W_B;
        end else if (i_a_req) begin
            gnt_vld = 1'b1;
            gnt_win = W_A;
        end else if (i_b_req) begin
            gnt_vld = 1'b1;
            gnt_win = W_B;
        end else if (i_dbg_req) begin
            gnt_vld = 1'b1;
            gnt_win = W_D;
        end
    end

    always_comb begin
        starve_nxt = starve;
        if (!i_b_req || (gnt_vld && gnt_win == W_B)) begin
            starve_nxt = '0;
        end else if (gnt_vld && gnt_win == W_A && starve != STARVE_MAX) begin
            starve_nxt = starve + 1'b1;
        end
    end

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = init_idx;
        wr_dat = '0;
        if (i_clk_en) begin
            if (state == ST_INIT) begin
                wr_en = 1'b1;
            end else if (state == ST_EXEC && win != W_D) begin
                if (!op_pop) begin
                    wr_en  = 1'b1;
                    wr_idx = ptr_inc;
                    wr_dat = op_data;
                end else if (!empty) begin
                    wr_en  = 1'b1;
                    wr_idx = ptr;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            rstk[wr_idx] <= wr_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ST_INIT;
            init_idx   <= 3'd0;
            ptr        <= 3'd7;
            count      <= 4'd0;
            starve     <= '0;
            win        <= W_A;
            op_pop     <= 1'b0;
            op_data    <= '0;
            dbg_ptr_q  <= 3'd0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            dbg_ack_q  <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            o_a_data   <= '0;
            o_b_data   <= '0;
            o_dbg_data <= '0;
        end else if (i_clk_en) begin
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            dbg_ack_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + 3'd1;
                    if (init_idx == 3'd7) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    starve <= starve_nxt;
                    if (gnt_vld) begin
                        win       <= gnt_win;
                        op_pop    <= (gnt_win == W_B) ? i_b_pop : i_a_pop;
                        op_data   <= (gnt_win == W_B) ? i_b_data : i_a_data;
                        dbg_ptr_q <= i_dbg_ptr;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
                    if (win == W_D) begin
                        o_dbg_data <= rstk[dbg_ptr_q];
                        dbg_ack_q  <= 1'b1;
                    end else begin
                        if (!op_pop) begin
                            ptr   <= ptr_inc;
                            count <= full ? count : count + 4'd1;
                            ovf_q <= full;
                        end else if (!empty) begin
                            ptr   <= ptr_dec;
                            count <= count - 4'd1;
                        end else begin
                            unf_q <= 1'b1;
                        end
                        if (win == W_A) begin
                            a_ack_q <= 1'b1;
                            if (op_pop) o_a_data <= pop_dat;
                        end else begin
                            b_ack_q <= 1'b1;
                            if (op_pop) o_b_data <= pop_dat;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Pulses are registered but masked by the enable so a stalled cycle never shows an ack.
    assign o_a_ack      = a_ack_q & i_clk_en;
    assign o_b_ack      = b_ack_q & i_clk_en;
    assign o_dbg_ack    = dbg_ack_q & i_clk_en;
    assign o_overflow   = ovf_q & i_clk_en;
    assign o_underflow  = unf_q & i_clk_en;
    assign o_rstk_ptr   = ptr;
    assign o_rstk_count = count;
    assign o_busy       = (state != ST_IDLE);

endmodule
